serial_adder: RTL and testbench

- Bit-serial adder. Loads two WIDTH-bit operands plus carry-in, then adds them one bit per clock, LSB first, through a single one-bit full-adder slice (the existing full_adder cell, instantiated once).
- A carry flip-flop closes the loop between bit cycles.
- Sits directly upstream of the full_adder and sequences it. Trades WIDTH cycles of latency for one adder cell.
- Result is registered and held for downstream consumers.

---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: a single full_adder slice adds two WIDTH-bit operands
// LSB first, one bit per clock, with a carry flip-flop between bit cycles.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_sliceSum;
    logic             w_sliceCout;
    logic             w_accept;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_accNext;

    full_adder u_slice (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sliceSum),
        .o_cout (w_sliceCout)
    );

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastBit = (r_cnt == LAST_BIT);
    // The accumulator keeps only the upper WIDTH-1 bits; the full result is
    // formed on the final edge by prepending that edge's slice bit.
    assign w_accNext = {w_sliceSum, r_acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = start ? SHIFT : IDLE;
            SHIFT:   w_nextState = w_lastBit ? DONE : SHIFT;
            DONE:    w_nextState = start ? SHIFT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_acc   <= w_accNext[WIDTH-1:1];
            r_carry <= w_sliceCout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_lastBit) begin
                r_sum  <= w_accNext;
                r_cout <= w_sliceCout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table vectors, hand-written corner
// sequences, random operands at WIDTH=8 and an exhaustive sweep at WIDTH=4.

module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int nVectors;
    int nMiscompares;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expSum;
        logic       expCout;
    } vec_t;

    vec_t vectors[7];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on the 8-bit instance; with scramble set, the operands
    // and start are disturbed during the first shift cycles.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                                 input logic opCin, input bit scramble);
        logic [8:0] expected;
        int k;
        expected = 9'(opA) + 9'(opB) + 9'(opCin);
        a8 = opA;
        b8 = opB;
        cin8 = opCin;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 40) begin
            checkOutput("busy during shift", 64'(busy8), 64'd1);
            if (scramble && k < 5) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                cin8 = 1'($urandom);
                start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            step();
            k++;
        end
        checkOutput("edges from accept to done", 64'(k + 1), 64'd9);
        checkOutput("sum", 64'(sum8), 64'(expected[7:0]));
        checkOutput("cout", 64'(cout8), 64'(expected[8]));
        step();
        checkOutput("done single cycle", 64'(done8), 64'd0);
    endtask

    initial begin
        logic [8:0] exp9;
        logic [4:0] exp5;
        logic [3:0] curA;
        logic [3:0] curB;
        logic       curC;
        int k;

        nVectors = 0;
        nMiscompares = 0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        vectors[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        vectors[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vectors[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vectors[3] = '{8'h10, 8'h20, 1'b1, 8'h31, 1'b0};
        vectors[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
        vectors[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vectors[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        // Reset for two cycles, then stay idle for twenty.
        step();
        step();
        checkOutput("outputs in reset", 64'({busy8, done8, cout8, sum8}), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("idle after reset", 64'({busy8, done8, cout8, sum8}), 64'd0);
        end

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin, 1'b0);
            checkOutput("table sum", 64'(sum8), 64'(vectors[i].expSum));
            checkOutput("table cout", 64'(cout8), 64'(vectors[i].expCout));
        end

        // Operands and start disturbed mid-shift must not affect the result.
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1);
        checkOutput("sum held after ignored start", 64'(sum8), 64'h31);

        // start held high: back-to-back operations every nine cycles.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
        step();
        k = 0;
        while (!done8 && k < 40) begin step(); k++; end
        checkOutput("first back-to-back latency", 64'(k + 1), 64'd9);
        for (int r = 0; r < 3; r++) begin
            checkOutput("b2b sum", 64'({cout8, sum8}), 64'h031);
            step();
            checkOutput("b2b no idle gap", 64'({busy8, done8}), 64'b10);
            k = 1;
            while (!done8 && k < 40) begin step(); k++; end
            checkOutput("b2b done spacing", 64'(k), 64'd9);
        end
        start8 = 1'b0;
        step();

        // Reset in the 4th shift cycle of AA+55 aborts with no done pulse.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        checkOutput("busy before abort", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("outputs after async reset", 64'({busy8, done8, cout8, sum8}), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("no done after abort", 64'({busy8, done8, cout8, sum8}), 64'd0);
        end
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b0);
        checkOutput("sum after abort", 64'(sum8), 64'h03);

        // Random operands against plain integer addition.
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            applyStimulus(ra, rb, rc, 1'b0);
            checkOutput("random {cout,sum}", 64'({cout8, sum8}), 64'(exp9));
        end

        // Exhaustive WIDTH=4, back-to-back with start held high.
        curA = 4'd0; curB = 4'd0; curC = 1'b0;
        a4 = curA; b4 = curB; cin4 = curC; start4 = 1'b1;
        step();
        k = 0;
        for (int i = 0; i < 512; i++) begin
            while (!done4 && k < 40) begin step(); k++; end
            checkOutput("w4 done spacing", 64'(k), (i == 0) ? 64'd4 : 64'd5);
            exp5 = 5'(curA) + 5'(curB) + 5'(curC);
            checkOutput("w4 {cout,sum}", 64'({cout4, sum4}), 64'(exp5));
            if (i < 511) begin
                curA = 4'((i + 1) >> 5);
                curB = 4'((i + 1) >> 1);
                curC = 1'((i + 1));
                a4 = curA; b4 = curB; cin4 = curC;
            end else begin
                start4 = 1'b0;
            end
            step();
            k = 1;
        end
        checkOutput("w4 idle at end", 64'({busy4, done4}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
